// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch sequencer that decides when and what the program counter loads
module pc_sequencer #(
    parameter int                 N_BITS      = 32,
    parameter logic [N_BITS-1:0]  RESET_PC    = 32'h00400000,
    parameter logic [N_BITS-1:0]  EXC_VECTOR  = 32'h80000180,
    parameter int                 BOOT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] pc_i,
    input  logic              imem_ack_i,
    input  logic              stall_i,
    input  logic              exception_i,
    input  logic              jr_i,
    input  logic [N_BITS-1:0] jr_addr_i,
    input  logic              jump_i,
    input  logic [25:0]       jump_target_i,
    input  logic              branch_taken_i,
    input  logic [N_BITS-1:0] branch_offset_i,
    output logic              imem_req_o,
    output logic              pc_write_n_o,
    output logic [N_BITS-1:0] new_pc_o,
    output logic [N_BITS-1:0] epc_o,
    output logic              addr_err_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_UPDATE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        boot_cnt_q, boot_cnt_d;
    logic [N_BITS-1:0] new_pc_q, new_pc_d;
    logic [N_BITS-1:0] epc_q, epc_d;
    logic              addr_err_q, addr_err_d;

    logic [N_BITS-1:0] pc_plus4;
    logic [N_BITS-1:0] dec_pc;
    logic              dec_fault;
    logic              dec_misaligned;
    logic              decide;

    // Next-PC selection; only committed on the edge where decide is true.
    always_comb begin
        pc_plus4       = pc_i + N_BITS'(4);
        dec_pc         = pc_plus4;
        dec_fault      = 1'b0;
        dec_misaligned = 1'b0;
        if (exception_i) begin
            dec_pc    = EXC_VECTOR;
            dec_fault = 1'b1;
        end else if (jr_i && (jr_addr_i[1:0] != 2'b00)) begin
            dec_pc         = EXC_VECTOR;
            dec_fault      = 1'b1;
            dec_misaligned = 1'b1;
        end else if (jr_i) begin
            dec_pc = jr_addr_i;
        end else if (jump_i) begin
            dec_pc = {pc_plus4[N_BITS-1:28], jump_target_i, 2'b00};
        end else if (branch_taken_i) begin
            dec_pc = pc_plus4 + (branch_offset_i << 2);
        end
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        new_pc_d   = new_pc_q;
        epc_d      = epc_q;
        addr_err_d = 1'b0;
        decide     = 1'b0;
        case (state_q)
            S_BOOT: begin
                if (boot_cnt_q == 4'(BOOT_CYCLES - 1)) begin
                    state_d = S_FETCH;
                end else begin
                    boot_cnt_d = boot_cnt_q + 4'd1;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (imem_ack_i) begin
                    if (stall_i) begin
                        state_d = S_HOLD;
                    end else begin
                        decide = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    decide = 1'b1;
                end
            end
            S_UPDATE: state_d = S_FETCH;
            default:  state_d = S_BOOT;
        endcase
        if (decide) begin
            state_d    = S_UPDATE;
            new_pc_d   = dec_pc;
            addr_err_d = dec_misaligned;
            if (dec_fault) begin
                epc_d = pc_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_BOOT;
            boot_cnt_q <= 4'd0;
            new_pc_q   <= RESET_PC;
            epc_q      <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            new_pc_q   <= new_pc_d;
            epc_q      <= epc_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign imem_req_o   = (state_q == S_FETCH);
    assign pc_write_n_o = (state_q != S_UPDATE);
    assign busy_o       = (state_q != S_FETCH);
    assign new_pc_o     = new_pc_q;
    assign epc_o        = epc_q;
    assign addr_err_o   = addr_err_q;

endmodule
